// File: rtl/reg_wb.sv
// -----------------------------------------------------------------------------
// reg_wb -- register-file owner and writeback stage of the 16-bit multi-cycle
// CPU.
//
// Holds the eight 16-bit general registers and commits writeback results into
// them. Each register has a pending-write counter. Decode raises iss_en for an
// instruction that will write n_reg_iss, and an accepted issue increments that
// register's counter. A commit on wb_en decrements the counter of n_reg_in.
// Decode treats pending[i] as "value not yet valid". The forwarding port
// (fwd_valid / n_reg_out / reg_out) repeats the most recent commit one cycle
// later so decode can bypass the register read.
//
// Ports
//   clk_wb      in   1   stage clock, all state changes on posedge
//   rst_n       in   1   asynchronous active-low reset
//   iss_en      in   1   decode wants to issue a writer of n_reg_iss
//   n_reg_iss   in   3   destination of the issuing instruction
//   wb_en       in   1   writeback commit strobe
//   n_reg_in    in   3   destination of the commit
//   wb_data     in  16   value to commit
//   reg0..reg7  out 16   architectural register contents (registered)
//   pending     out  8   bit i set while counter i is nonzero (registered)
//   iss_stall   out  1   combinational: issue target counter is saturated
//   wb_err      out  1   sticky: a commit hit a register with no pending write
//   fwd_valid   out  1   a commit happened on the previous edge
//   n_reg_out   out  3   register number of the last commit
//   reg_out     out 16   data of the last commit
// -----------------------------------------------------------------------------
module reg_wb #(
  parameter int CNT_W = 2
) (
  input  logic        clk_wb,
  input  logic        rst_n,
  input  logic        iss_en,
  input  logic [2:0]  n_reg_iss,
  input  logic        wb_en,
  input  logic [2:0]  n_reg_in,
  input  logic [15:0] wb_data,
  output logic [15:0] reg0,
  output logic [15:0] reg1,
  output logic [15:0] reg2,
  output logic [15:0] reg3,
  output logic [15:0] reg4,
  output logic [15:0] reg5,
  output logic [15:0] reg6,
  output logic [15:0] reg7,
  output logic [7:0]  pending,
  output logic        iss_stall,
  output logic        wb_err,
  output logic        fwd_valid,
  output logic [2:0]  n_reg_out,
  output logic [15:0] reg_out
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  // Next value of one pending counter. An increment and a decrement in the
  // same cycle cancel out. The counter saturates at both ends, so it never
  // wraps even if the surrounding logic misbehaves.
  function automatic logic [CNT_W-1:0] cnt_step(
    input logic [CNT_W-1:0] cnt,
    input logic             inc,
    input logic             dec
  );
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    case ({inc, dec})
      2'b10:   nxt = (cnt == CNT_MAX)  ? cnt : cnt + CNT_ONE;
      2'b01:   nxt = (cnt == CNT_ZERO) ? cnt : cnt - CNT_ONE;
      default: nxt = cnt;
    endcase
    return nxt;
  endfunction

  // A lone commit to a register with no pending write is an error. A commit
  // paired with an accepted issue of the same register is not an error.
  function automatic logic cnt_underflow(
    input logic [CNT_W-1:0] cnt,
    input logic             inc,
    input logic             dec
  );
    logic hit;
    if (dec && !inc) begin
      hit = (cnt == CNT_ZERO);
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0]      regs_r [8];
  logic [CNT_W-1:0] cnt_r [8];
  logic [CNT_W-1:0] cnt_nxt_s [8];
  logic [7:0]       pending_r;
  logic             wb_err_r;
  logic             fwd_valid_r;
  logic [2:0]       n_reg_out_r;
  logic [15:0]      reg_out_r;

  logic             iss_stall_s;
  logic             iss_acc_s;
  logic [7:0]       inc_s;
  logic [7:0]       dec_s;
  logic             err_hit_s;

  // Stall looks only at the current counter. A commit in the same cycle that
  // frees a slot does not cancel the stall.
  always_comb begin
    iss_stall_s = 1'b0;
    if (iss_en) begin
      iss_stall_s = (cnt_r[n_reg_iss] == CNT_MAX);
    end else begin
      iss_stall_s = 1'b0;
    end
  end

  assign iss_acc_s = iss_en && !iss_stall_s;

  // One-hot increment and decrement requests per register. An X on
  // n_reg_in matches nothing here, so no register is updated.
  always_comb begin
    inc_s = 8'h00;
    dec_s = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (iss_acc_s && (n_reg_iss == 3'(i))) begin
        inc_s[i] = 1'b1;
      end else begin
        inc_s[i] = 1'b0;
      end
      if (wb_en && (n_reg_in == 3'(i))) begin
        dec_s[i] = 1'b1;
      end else begin
        dec_s[i] = 1'b0;
      end
    end
  end

  // Next counter values and the error condition.
  always_comb begin
    err_hit_s = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cnt_nxt_s[i] = cnt_step(cnt_r[i], inc_s[i], dec_s[i]);
      if (cnt_underflow(cnt_r[i], inc_s[i], dec_s[i])) begin
        err_hit_s = 1'b1;
      end else begin
        err_hit_s = err_hit_s;
      end
    end
  end

  // Scoreboard counters and the registered pending view of them.
  always_ff @(posedge clk_wb or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      pending_r <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        cnt_r[i]     <= cnt_nxt_s[i];
        pending_r[i] <= (cnt_nxt_s[i] != CNT_ZERO);
      end
    end
  end

  // Register file write. Every commit is performed, including erroneous ones.
  always_ff @(posedge clk_wb or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (dec_s[i]) begin
          regs_r[i] <= wb_data;
        end
      end
    end
  end

  // Sticky writeback error flag, cleared only by reset.
  always_ff @(posedge clk_wb or negedge rst_n) begin
    if (!rst_n) begin
      wb_err_r <= 1'b0;
    end else if (err_hit_s) begin
      wb_err_r <= 1'b1;
    end
  end

  // Forwarding port. Register number and data hold between commits.
  always_ff @(posedge clk_wb or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_r <= 1'b0;
      n_reg_out_r <= 3'b000;
      reg_out_r   <= 16'h0000;
    end else begin
      fwd_valid_r <= wb_en;
      if (wb_en) begin
        n_reg_out_r <= n_reg_in;
        reg_out_r   <= wb_data;
      end
    end
  end

  assign reg0      = regs_r[0];
  assign reg1      = regs_r[1];
  assign reg2      = regs_r[2];
  assign reg3      = regs_r[3];
  assign reg4      = regs_r[4];
  assign reg5      = regs_r[5];
  assign reg6      = regs_r[6];
  assign reg7      = regs_r[7];
  assign pending   = pending_r;
  assign iss_stall = iss_stall_s;
  assign wb_err    = wb_err_r;
  assign fwd_valid = fwd_valid_r;
  assign n_reg_out = n_reg_out_r;
  assign reg_out   = reg_out_r;

endmodule

// File: tb/tb_reg_wb.sv
// -----------------------------------------------------------------------------
// tb_reg_wb -- self-checking bench for reg_wb.
// The drive task applies one cycle of stimulus and updates a reference model.
// It also pushes each commit to a queue. A monitor pops that queue after each
// edge and checks the forwarding port and the written register. The scenario
// tasks check stall, pending, wb_err and register values inline.
// -----------------------------------------------------------------------------
module tb_reg_wb;

  logic        clk_wb;
  logic        rst_n;
  logic        iss_en;
  logic [2:0]  n_reg_iss;
  logic        wb_en;
  logic [2:0]  n_reg_in;
  logic [15:0] wb_data;
  logic [15:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
  logic [7:0]  pending;
  logic        iss_stall;
  logic        wb_err;
  logic        fwd_valid;
  logic [2:0]  n_reg_out;
  logic [15:0] reg_out;

  reg_wb #(.CNT_W(2)) dut (
    .clk_wb(clk_wb), .rst_n(rst_n),
    .iss_en(iss_en), .n_reg_iss(n_reg_iss),
    .wb_en(wb_en), .n_reg_in(n_reg_in), .wb_data(wb_data),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .reg4(reg4), .reg5(reg5), .reg6(reg6), .reg7(reg7),
    .pending(pending), .iss_stall(iss_stall), .wb_err(wb_err),
    .fwd_valid(fwd_valid), .n_reg_out(n_reg_out), .reg_out(reg_out)
  );

  initial clk_wb = 1'b0;
  always #5 clk_wb = ~clk_wb;

  logic [15:0] regs_v [8];
  assign regs_v[0] = reg0;
  assign regs_v[1] = reg1;
  assign regs_v[2] = reg2;
  assign regs_v[3] = reg3;
  assign regs_v[4] = reg4;
  assign regs_v[5] = reg5;
  assign regs_v[6] = reg6;
  assign regs_v[7] = reg7;

  typedef struct packed {
    logic [2:0]  n;
    logic [15:0] d;
  } commit_t;

  commit_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model.
  int          m_cnt [8];
  logic [15:0] m_reg [8];
  logic        m_err;
  logic        m_stall;
  logic [2:0]  last_n;
  logic [15:0] last_d;

  function automatic logic [7:0] m_pend();
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 0;
      m_reg[i] = 16'h0000;
    end
    m_err   = 1'b0;
    m_stall = 1'b0;
    last_n  = 3'd0;
    last_d  = 16'h0000;
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus after the falling edge and update the model.
  task automatic drive(input logic ie, input logic [2:0] ni, input logic we,
                       input logic [2:0] nw, input logic [15:0] d);
    logic acc;
    @(negedge clk_wb);
    iss_en = ie; n_reg_iss = ni; wb_en = we; n_reg_in = nw; wb_data = d;
    m_stall = ie && (m_cnt[ni] == 3);
    acc = ie && !m_stall;
    if (we) begin
      m_reg[nw] = d;
      exp_q.push_back({nw, d});
    end
    if (!(acc && we && (ni == nw))) begin
      if (acc) m_cnt[ni]++;
      if (we) begin
        if (m_cnt[nw] > 0) m_cnt[nw]--;
        else m_err = 1'b1;
      end
    end
    #1;
  endtask

  task automatic step();
    @(posedge clk_wb);
    #2;
  endtask

  // Scoreboard monitor: after each edge, compare the forwarding port and the
  // committed register against the oldest queued commit.
  always @(posedge clk_wb) begin
    commit_t c;
    #1;
    if (rst_n === 1'b1) begin
      if (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        last_n = c.n;
        last_d = c.d;
        checks++;
        if (fwd_valid !== 1'b1 || n_reg_out !== c.n || reg_out !== c.d || regs_v[c.n] !== c.d) begin
          errors++;
          $display("FAIL sb_commit got v=%b n=%0d d=%h reg=%h want v=1 n=%0d d=%h",
                   fwd_valid, n_reg_out, reg_out, regs_v[c.n], c.n, c.d);
        end
      end else begin
        checks++;
        if (fwd_valid !== 1'b0 || n_reg_out !== last_n || reg_out !== last_d) begin
          errors++;
          $display("FAIL sb_idle got v=%b n=%0d d=%h want v=0 n=%0d d=%h",
                   fwd_valid, n_reg_out, reg_out, last_n, last_d);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    iss_en = 1'b0; n_reg_iss = 3'd0; wb_en = 1'b0; n_reg_in = 3'd0; wb_data = 16'h0000;
    model_reset();
    #2;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (regs_v[i] !== 16'h0000) begin
        errors++;
        $display("FAIL reset_reg%0d got %h want 0000", i, regs_v[i]);
      end
    end
    checks++;
    if (pending !== 8'h00 || wb_err !== 1'b0 || fwd_valid !== 1'b0 ||
        n_reg_out !== 3'd0 || reg_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_flags got pend=%h err=%b v=%b n=%0d d=%h want all zero",
               pending, wb_err, fwd_valid, n_reg_out, reg_out);
    end
    @(negedge clk_wb);
    rst_n = 1'b1;
  endtask

  task automatic test_issue_commit();
    drive(1'b1, 3'd3, 1'b0, 3'd0, 16'h0000);
    checks++;
    if (iss_stall !== 1'b0) begin errors++; $display("FAIL ic_stall got %b want 0", iss_stall); end
    step();
    checks++;
    if (pending !== 8'h08) begin errors++; $display("FAIL ic_pend_issue got %h want 08", pending); end
    drive(1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
    step();
    checks++;
    if (pending !== 8'h08) begin errors++; $display("FAIL ic_pend_hold got %h want 08", pending); end
    drive(1'b0, 3'd0, 1'b1, 3'd3, 16'hBEEF);
    step();
    checks++;
    if (reg3 !== 16'hBEEF || pending !== 8'h00 || fwd_valid !== 1'b1 ||
        n_reg_out !== 3'd3 || reg_out !== 16'hBEEF) begin
      errors++;
      $display("FAIL ic_commit got r3=%h pend=%h v=%b n=%0d d=%h want BEEF 00 1 3 BEEF",
               reg3, pending, fwd_valid, n_reg_out, reg_out);
    end
    drive(1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
    step();
    checks++;
    if (fwd_valid !== 1'b0 || n_reg_out !== 3'd3 || reg_out !== 16'hBEEF) begin
      errors++;
      $display("FAIL ic_idle got v=%b n=%0d d=%h want 0 3 BEEF", fwd_valid, n_reg_out, reg_out);
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd5, 1'b0, 3'd0, 16'h0000);
      checks++;
      if (iss_stall !== 1'b0) begin errors++; $display("FAIL st_issue%0d got stall %b want 0", k, iss_stall); end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 3'd5, 1'b0, 3'd0, 16'h0000);
      checks++;
      if (iss_stall !== m_stall || m_stall !== 1'b1) begin
        errors++;
        $display("FAIL st_full%0d got stall %b want 1", k, iss_stall);
      end
      step();
    end
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 3'd0, 1'b1, 3'd5, 16'(k));
      step();
    end
    checks++;
    if (reg5 !== 16'h0003 || pending !== m_pend() || pending[5] !== 1'b0 || wb_err !== 1'b0) begin
      errors++;
      $display("FAIL st_drain got r5=%h pend=%h err=%b want 0003 %h 0", reg5, pending, wb_err, m_pend());
    end
  endtask

  task automatic test_same_cycle();
    drive(1'b1, 3'd2, 1'b0, 3'd0, 16'h0000);
    step();
    drive(1'b1, 3'd2, 1'b1, 3'd2, 16'h00AA);
    checks++;
    if (iss_stall !== 1'b0) begin errors++; $display("FAIL sc_stall got %b want 0", iss_stall); end
    step();
    checks++;
    if (reg2 !== 16'h00AA || pending[2] !== 1'b1 || wb_err !== 1'b0) begin
      errors++;
      $display("FAIL sc_hold got r2=%h p2=%b err=%b want 00AA 1 0", reg2, pending[2], wb_err);
    end
    drive(1'b0, 3'd0, 1'b1, 3'd2, 16'h00AB);
    step();
    checks++;
    if (pending !== m_pend() || pending[2] !== 1'b0 || wb_err !== 1'b0) begin
      errors++;
      $display("FAIL sc_drain got pend=%h err=%b want %h 0", pending, wb_err, m_pend());
    end
  endtask

  task automatic test_stall_release();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd1, 1'b0, 3'd0, 16'h0000);
      step();
    end
    drive(1'b1, 3'd1, 1'b1, 3'd1, 16'h1111);
    checks++;
    if (iss_stall !== 1'b1) begin errors++; $display("FAIL sr_stall got %b want 1", iss_stall); end
    step();
    drive(1'b1, 3'd1, 1'b0, 3'd0, 16'h0000);
    checks++;
    if (iss_stall !== 1'b0) begin errors++; $display("FAIL sr_accept got %b want 0", iss_stall); end
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'd0, 1'b1, 3'd1, 16'h2220 + 16'(k));
      step();
    end
    checks++;
    if (pending !== 8'h00 || wb_err !== 1'b0 || reg1 !== 16'h2222) begin
      errors++;
      $display("FAIL sr_drain got pend=%h err=%b r1=%h want 00 0 2222", pending, wb_err, reg1);
    end
  endtask

  task automatic test_err();
    drive(1'b0, 3'd0, 1'b1, 3'd7, 16'h5555);
    step();
    checks++;
    if (reg7 !== 16'h5555 || wb_err !== 1'b1 || m_err !== 1'b1) begin
      errors++;
      $display("FAIL err_set got r7=%h err=%b want 5555 1", reg7, wb_err);
    end
    drive(1'b1, 3'd0, 1'b0, 3'd0, 16'h0000);
    step();
    drive(1'b0, 3'd0, 1'b1, 3'd0, 16'h0F0F);
    step();
    checks++;
    if (wb_err !== 1'b1 || reg0 !== 16'h0F0F || pending !== 8'h00) begin
      errors++;
      $display("FAIL err_sticky got err=%b r0=%h pend=%h want 1 0F0F 00", wb_err, reg0, pending);
    end
  endtask

  task automatic test_reset_midrun();
    drive(1'b1, 3'd4, 1'b0, 3'd0, 16'h0000);
    step();
    drive(1'b1, 3'd6, 1'b1, 3'd4, 16'h1234);
    step();
    checks++;
    if (reg4 !== 16'h1234 || pending !== 8'h40) begin
      errors++;
      $display("FAIL mr_pre got r4=%h pend=%h want 1234 40", reg4, pending);
    end
    drive(1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (reg4 !== 16'h0000 || pending !== 8'h00 || wb_err !== 1'b0 || fwd_valid !== 1'b0 ||
        n_reg_out !== 3'd0 || reg_out !== 16'h0000) begin
      errors++;
      $display("FAIL mr_async got r4=%h pend=%h err=%b v=%b n=%0d d=%h want all zero",
               reg4, pending, wb_err, fwd_valid, n_reg_out, reg_out);
    end
    model_reset();
    @(negedge clk_wb);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
    step();
    checks++;
    if (wb_err !== 1'b0 || pending !== 8'h00) begin
      errors++;
      $display("FAIL mr_after got err=%b pend=%h want 0 00", wb_err, pending);
    end
  endtask

  initial begin
    test_reset();
    test_issue_commit();
    test_stall();
    test_same_cycle();
    test_stall_release();
    test_err();
    test_reset_midrun();
    repeat (2) @(negedge clk_wb);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wb.md
# reg_wb

Register-file owner and writeback stage of the 16-bit multi-cycle CPU: the write-side counterpart of the decode-stage register read. It holds the eight 16-bit general registers, commits writeback results into them, and tracks outstanding writes per register with a scoreboard. Decode uses that scoreboard to detect hazards, and a registered forwarding port carries the most recent commit back to it.

## Interface
Parameters:
- CNT_W, 2, width of each per-register pending-write counter; maximum outstanding writes per register is 2^CNT_W-1 (3 by default)

Ports:
- clk_wb  in  1  stage clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- iss_en  in  1  decode requests issue of an instruction that will write n_reg_iss
- n_reg_iss  in  3  destination register number of the issuing instruction
- wb_en  in  1  writeback commit strobe
- n_reg_in  in  3  destination register number of the commit
- wb_data  in  16  value to commit
- reg0..reg7  out  16 each  architectural register contents
- pending  out  8  bit i = 1 when counter i is nonzero
- iss_stall  out  1  combinational: iss_en && counter[n_reg_iss] == max
- wb_err  out  1  sticky flag: a commit arrived for a register whose counter was 0
- fwd_valid  out  1  registered: a commit happened on the previous edge
- n_reg_out  out  3  registered register number of the last commit
- reg_out  out  16  registered data of the last commit

## Operation
- Reset, asynchronous and taking effect immediately: reg0..reg7 = 16'h0000, all counters = 0, pending = 8'h00, wb_err = 0, fwd_valid = 0, n_reg_out = 3'b000, reg_out = 16'h0000.
- Issue accepted = iss_en && !iss_stall. An accepted issue increments counter[n_reg_iss].
- Commit (wb_en): reg[n_reg_in] <= wb_data. Every commit is performed, including an erroneous one.
- On a commit, if counter[n_reg_in] > 0, it decrements. Otherwise the counter stays at 0 and wb_err sets. wb_err stays set until reset.
- Accepted issue and commit to the same register in the same cycle: the counter is unchanged, and wb_err is not set even when the counter is 0.
- Accepted issue and commit to different registers: both counters update independently.
- iss_stall is evaluated on the current counter value only. A same-cycle commit that would free a slot does not cancel the stall.
- Counters never wrap: an increment at max is impossible because the issue is stalled; a decrement at 0 is suppressed.
- Forwarding port on each edge:
  - fwd_valid <= wb_en.
  - When wb_en = 1: n_reg_out <= n_reg_in and reg_out <= wb_data.
  - When wb_en = 0: n_reg_out and reg_out hold their previous values.
- Unknown or X on n_reg_in while wb_en = 1 is a usage error. No register update is guaranteed in that case.

## Timing
- Commit latency is 1 cycle: data on wb_data at edge N appears on regK and reg_out after edge N.
- pending and the counters update on the same edge as the issue or commit that changes them.
- iss_stall has zero latency: it follows iss_en, n_reg_iss and the current counters combinationally.
- wb_err rises on the edge that captures the erroneous commit.
- Decode must treat pending[i] = 1 as "value not yet valid". When fwd_valid = 1 and n_reg_out = i, it may take reg_out in place of reg i.

## Test plan
- Reset, then hold rst_n low mid-run after writing r4 = 16'h1234: all registers read 0, pending = 0, wb_err = 0 and fwd_valid = 0 immediately, without waiting for a clock edge.
- Issue r3, then two cycles later commit r3 = 16'hBEEF: pending[3] is 1 from the issue edge until the commit edge. After the commit edge, reg3 = 16'hBEEF, fwd_valid = 1, n_reg_out = 3, reg_out = 16'hBEEF. The next idle cycle gives fwd_valid = 0 with n_reg_out and reg_out held.
- Three accepted issues to r5, then a fourth with iss_en held: iss_stall = 1 and the counter stays at 3. Three commits r5 = 1, 2, 3 leave reg5 = 3 and pending[5] = 0.
- With counter r2 = 1, issue r2 and commit r2 = 16'h00AA in the same cycle: counter stays 1, pending[2] = 1, reg2 = 16'h00AA.
- Commit r7 = 16'h5555 with no prior issue: reg7 = 16'h5555 and wb_err = 1. wb_err remains 1 through later valid traffic until rst_n goes low.
- Counter r1 = 3, with iss_en on r1 and a commit to r1 in the same cycle: iss_stall = 1, counter goes to 2, and the next-cycle issue is accepted.
